// File: rtl/seg7_pkg.sv
// Shared symbol codes and segment patterns for the seven-segment display blocks.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned CODE_W = 5;

    typedef logic [CODE_W-1:0] seg7_code_t;

    localparam seg7_code_t CODE_EQ    = 5'd16;
    localparam seg7_code_t CODE_BLANK = 5'd17;
    localparam seg7_code_t CODE_DASH  = 5'd18;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_EQ   = 7'b0110111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational symbol-code to active-low segment pattern decoder.
// Codes 0-15 are hex digits; every code past CODE_BLANK renders as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg7_code_t code,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (code)
            5'd0:       seg_c = 7'b1000000;
            5'd1:       seg_c = 7'b1111001;
            5'd2:       seg_c = 7'b0100100;
            5'd3:       seg_c = 7'b0110000;
            5'd4:       seg_c = 7'b0011001;
            5'd5:       seg_c = 7'b0010010;
            5'd6:       seg_c = 7'b0000010;
            5'd7:       seg_c = 7'b1111000;
            5'd8:       seg_c = 7'b0000000;
            5'd9:       seg_c = 7'b0010000;
            5'd10:      seg_c = 7'b0001000;
            5'd11:      seg_c = 7'b0000011;
            5'd12:      seg_c = 7'b1000110;
            5'd13:      seg_c = 7'b0100001;
            5'd14:      seg_c = 7'b0000110;
            5'd15:      seg_c = 7'b0001110;
            CODE_EQ:    seg_c = SEG_EQ;
            CODE_BLANK: seg_c = SEG_OFF;
            default:    seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a
// double-buffered frame, per-slot blanking guard and leading-zero suppression.
module seven_seg_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [5*NUM_DIGITS-1:0] wr_codes,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REFRESH_BITS-1:0] PRE_MAX  = '1;
    localparam logic [REFRESH_BITS-1:0] GUARD    = REFRESH_BITS'(GUARD_CYCLES);

    logic [REFRESH_BITS-1:0] presc;
    logic [IDX_W-1:0]        idx;
    logic                    boundary_c;

    seg7_code_t              wr_arr_c   [NUM_DIGITS];
    seg7_code_t              pend_codes [NUM_DIGITS];
    seg7_code_t              act_codes  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    pend_valid;

    logic [NUM_DIGITS-1:0]   supp_c;
    logic                    lead_c;
    seg7_code_t              sel_code_c;
    logic [6:0]              dec_seg_c;

    assign boundary_c = (presc == PRE_MAX) && (idx == LAST_IDX);

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            wr_arr_c[k] = wr_codes[CODE_W*k +: CODE_W];
        end
    end

    // Refresh prescaler and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + REFRESH_BITS'(1);
            if (presc == PRE_MAX) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Pending/active buffers; a write landing on the boundary bypasses pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_dp    <= '0;
            act_dp     <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                pend_codes[k] <= CODE_BLANK;
                act_codes[k]  <= CODE_BLANK;
            end
        end else if (boundary_c) begin
            pend_valid <= 1'b0;
            if (wr_en) begin
                act_dp <= wr_dp;
                for (int k = 0; k < NUM_DIGITS; k++) act_codes[k] <= wr_arr_c[k];
            end else if (pend_valid) begin
                act_dp <= pend_dp;
                for (int k = 0; k < NUM_DIGITS; k++) act_codes[k] <= pend_codes[k];
            end
        end else if (wr_en) begin
            pend_valid <= 1'b1;
            pend_dp    <= wr_dp;
            for (int k = 0; k < NUM_DIGITS; k++) pend_codes[k] <= wr_arr_c[k];
        end
    end

    // Zeros above the first nonzero digit are blanked; digit 0 always shows
    always_comb begin
        lead_c = 1'b1;
        supp_c = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (act_codes[k] != '0) lead_c = 1'b0;
            supp_c[k] = lead_c & lz_suppress;
        end
    end

    assign sel_code_c = supp_c[idx] ? CODE_BLANK : act_codes[idx];

    seg7_decode u_decode (
        .code  (sel_code_c),
        .seg_c (dec_seg_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary_c;
            if (presc < GUARD) begin
                seg <= SEG_OFF;
                dp  <= 1'b1;
                an  <= '1;
            end else begin
                seg <= dec_seg_c;
                dp  <= ~act_dp[idx];
                an  <= ~(NUM_DIGITS'(1) << idx);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed self-checking bench for seven_seg_mux with a 4-cycle slot and
// 1 guard cycle, so one frame spans 16 clocks.
module tb_seven_seg_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [19:0] wr_codes;
    logic [3:0]  wr_dp;
    logic        lz_suppress;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_BITS (2),
        .GUARD_CYCLES (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_codes    (wr_codes),
        .wr_dp       (wr_dp),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_done  (frame_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [19:0] pack4(input logic [4:0] c3, input logic [4:0] c2,
                                          input logic [4:0] c1, input logic [4:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic write(input logic [19:0] c, input logic [3:0] d);
        wr_codes = c;
        wr_dp    = d;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        chk({tag, "_frame_wait"}, 16'(frame_done), 16'(1'b1));
    endtask

    // Call right after a frame_done sample; walks one whole frame.
    task automatic scan_frame(input logic [27:0] segs, input logic [3:0] dpreq, input string tag);
        int pulses = 0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
            if (j % 4 == 1) begin
                chk({tag, "_guard_an"},  16'(an),  16'(4'b1111));
                chk({tag, "_guard_seg"}, 16'(seg), 16'(7'h7F));
                chk({tag, "_guard_dp"},  16'(dp),  16'(1'b1));
            end else if (j % 4 == 2) begin
                int d;
                logic [3:0] e_an;
                logic [6:0] e_seg;
                logic       e_dp;
                d     = (j - 2) / 4;
                e_an  = ~(4'b0001 << d);
                e_seg = segs[7*d +: 7];
                e_dp  = ~dpreq[d];
                chk({tag, "_an"},  16'(an),  16'(e_an));
                chk({tag, "_seg"}, 16'(seg), 16'(e_seg));
                chk({tag, "_dp"},  16'(dp),  16'(e_dp));
            end
        end
        chk({tag, "_fd_pulses"}, 16'(pulses), 16'(1));
        chk({tag, "_fd_end"}, 16'(frame_done), 16'(1'b1));
    endtask

    initial begin
        reset       = 1'b1;
        wr_en       = 1'b0;
        wr_codes    = '0;
        wr_dp       = '0;
        lz_suppress = 1'b0;

        ticks(3);
        chk("rst_seg", 16'(seg), 16'(7'h7F));
        chk("rst_dp",  16'(dp),  16'(1'b1));
        chk("rst_an",  16'(an),  16'(4'b1111));
        chk("rst_fd",  16'(frame_done), 16'(1'b0));

        // Scan up to digit 2, then reset asynchronously between edges
        reset = 1'b0;
        ticks(10);
        chk("pre_rst_an",  16'(an),  16'(4'b1011));
        chk("pre_rst_seg", 16'(seg), 16'(7'h7F));
        #2 reset = 1'b1;
        #1;
        chk("async_rst_seg", 16'(seg), 16'(7'h7F));
        chk("async_rst_dp",  16'(dp),  16'(1'b1));
        chk("async_rst_an",  16'(an),  16'(4'b1111));
        chk("async_rst_fd",  16'(frame_done), 16'(1'b0));
        #1 reset = 1'b0;
        tick();
        chk("post_rst_guard_an", 16'(an), 16'(4'b1111));
        tick();
        chk("post_rst_an",  16'(an),  16'(4'b1110));
        chk("post_rst_seg", 16'(seg), 16'(7'h7F));
        chk("post_rst_dp",  16'(dp),  16'(1'b1));

        // Basic frame of {3,2,1,0}
        write(pack4(5'd3, 5'd2, 5'd1, 5'd0), 4'b0000);
        wait_frame("basic");
        scan_frame({7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}, 4'b0000, "basic");

        // Mid-frame writes (last wins) must not disturb the current frame
        ticks(3);
        write(pack4(5'd9, 5'd9, 5'd9, 5'd9), 4'b1111);
        ticks(1);
        write(pack4(5'd15, 5'd14, 5'd13, 5'd12), 4'b1001);
        ticks(4);
        chk("tear_d2_an",  16'(an),  16'(4'b1011));
        chk("tear_d2_seg", 16'(seg), 16'(7'b0100100));
        ticks(4);
        chk("tear_d3_an",  16'(an),  16'(4'b0111));
        chk("tear_d3_seg", 16'(seg), 16'(7'b0110000));
        ticks(2);
        chk("tear_fd", 16'(frame_done), 16'(1'b1));
        scan_frame({7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110}, 4'b1001, "tear");

        // Write landing exactly on the boundary cycle
        ticks(15);
        write(pack4(5'd16, 5'd17, 5'd18, 5'd5), 4'b0000);
        chk("bypass_fd", 16'(frame_done), 16'(1'b1));
        scan_frame({7'b0110111, 7'h7F, 7'b0111111, 7'b0010010}, 4'b0000, "bypass");

        // Leading-zero suppression, all zeros with a dp on digit 2
        lz_suppress = 1'b1;
        ticks(3);
        write(pack4(5'd0, 5'd0, 5'd0, 5'd0), 4'b0100);
        wait_frame("lz0");
        scan_frame({7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0100, "lz0");

        // Suppression stops at the first nonzero digit
        ticks(3);
        write(pack4(5'd0, 5'd7, 5'd0, 5'd0), 4'b0000);
        wait_frame("lz7");
        scan_frame({7'h7F, 7'b1111000, 7'b1000000, 7'b1000000}, 4'b0000, "lz7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
